// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster, pixel- and line-doubled from a 320x240 buffer.
// Define VGA_SCANOUT_TEST_PATTERN_EN to add the testPattern colour-bar input.
module vga_scanout #(
  parameter logic [2:0] LATCH_PHASE  = 3'd7,
  parameter int         H_VISIBLE    = 640,
  parameter int         H_SYNC_START = 656,
  parameter int         H_SYNC_END   = 752,
  parameter int         H_TOTAL      = 800,
  parameter int         V_VISIBLE    = 480,
  parameter int         V_SYNC_START = 490,
  parameter int         V_SYNC_END   = 492,
  parameter int         V_TOTAL      = 525
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] clockPhase,
  output logic [8:0] readXCoord,
  output logic [7:0] readYCoord,
  input  logic [7:0] pixel1,
  input  logic [7:0] pixel2,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hSync,
  output logic       vSync,
  output logic       visible,
  output logic       frameStart
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  ,
  input  logic       testPattern
`endif
);

  localparam logic [9:0] HV  = 10'(H_VISIBLE);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_END);
  localparam logic [9:0] HL  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VV  = 10'(V_VISIBLE);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VSE = 10'(V_SYNC_END);
  localparam logic [9:0] VL  = 10'(V_TOTAL - 1);
  localparam logic [7:0] PL  = 8'(H_TOTAL / 4 - 1);

  logic        aligned_q, aligned_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;
  logic [8:0]  rx_q, rx_d;
  logic [7:0]  ry_q, ry_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        vis_q, vis_d;
  logic        fs_q, fs_d;

  logic       step;
  logic       capture;
  logic [7:0] pidx;
  logic       last_pair;
  logic [9:0] fl;
  logic [7:0] pix;

  always_comb begin
    step      = aligned_q && (clockPhase == 3'd3 || clockPhase == 3'd7);
    capture   = (clockPhase == LATCH_PHASE) && h_q[1];
    aligned_d = aligned_q || (clockPhase == 3'd0);
    h_d       = h_q;
    v_d       = v_q;
    if (step) begin
      if (h_q == HL) begin
        h_d = 10'd0;
        v_d = (v_q == VL) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // capture and pair entry share an edge, so the fresh pair forwards
    shadow_d = capture ? {pixel1, pixel2} : shadow_q;
    active_d = active_q;
    if (step && h_d[1:0] == 2'd0) active_d = shadow_d;

    pidx      = h_d[9:2];
    last_pair = (pidx == PL);
    fl        = v_d;
    if (last_pair) fl = (v_d == VL) ? 10'd0 : v_d + 10'd1;
    rx_d = last_pair ? 9'd0 : {pidx + 8'd1, 1'b0};
    ry_d = (fl < VV) ? fl[8:1] : 8'd0;

    pix = h_d[1] ? active_d[7:0] : active_d[15:8];
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    if (testPattern) pix = {h_d[9:7], h_d[9:7], h_d[8:7]};
`endif

    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    vis_d = vis_q;
    fs_d  = 1'b0;
    if (step) begin
      vis_d = (h_d < HV) && (v_d < VV);
      rgb_d = vis_d ? pix : 8'd0;
      hs_d  = !((h_d >= HSS) && (h_d < HSE));
      vs_d  = !((v_d >= VSS) && (v_d < VSE));
      fs_d  = (h_d == 10'd0) && (v_d == VV);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aligned_q <= 1'b0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      shadow_q  <= 16'd0;
      active_q  <= 16'd0;
      rx_q      <= 9'd0;
      ry_q      <= 8'd0;
      rgb_q     <= 8'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      vis_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      aligned_q <= aligned_d;
      h_q       <= h_d;
      v_q       <= v_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      vis_q     <= vis_d;
      fs_q      <= fs_d;
    end
  end

  assign readXCoord = rx_q;
  assign readYCoord = ry_q;
  assign red        = rgb_q[7:5];
  assign green      = rgb_q[4:2];
  assign blue       = rgb_q[1:0];
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign visible    = vis_q;
  assign frameStart = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout on a short-frame raster.
// Full line timing, 10-line frame so whole frames fit in the run.
module tb_vga_scanout;

  localparam int HV  = 640;
  localparam int HSS = 656;
  localparam int HSE = 752;
  localparam int HT  = 800;
  localparam int VV  = 8;
  localparam int VSS = 9;
  localparam int VSE = 10;
  localparam int VT  = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] clockPhase;
  logic [8:0] readXCoord;
  logic [7:0] readYCoord;
  logic [7:0] pixel1, pixel2;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hSync, vSync, visible, frameStart;

  vga_scanout #(
    .V_VISIBLE(VV), .V_SYNC_START(VSS),
    .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clock(clock), .reset(reset),
    .clockPhase(clockPhase),
    .readXCoord(readXCoord),
    .readYCoord(readYCoord),
    .pixel1(pixel1), .pixel2(pixel2),
    .red(red), .green(green), .blue(blue),
    .hSync(hSync), .vSync(vSync),
    .visible(visible),
    .frameStart(frameStart)
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    , .testPattern(1'b0)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem(int x, int y);
    if (x == 0 && y == 0) return 8'hE0;
    if (x == 1 && y == 0) return 8'h1C;
    return 8'(x * 7 + y * 29 + 53);
  endfunction

  assign pixel1 = mem(int'(readXCoord), int'(readYCoord));
  assign pixel2 = mem(int'(readXCoord) + 1, int'(readYCoord));

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs, vs, vis, fs;
    logic [8:0] rx;
    logic [7:0] ry;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  bit m_al;
  int m_h, m_v;
  bit fresh;
  int clk_n = 0;
  int last_hfall = -1, hlow_start = 0;
  int vlow_start = 0, last_fs = -1, fs_cnt = 0;
  logic hs_p = 1'b1, vs_p = 1'b1;

  function automatic logic [16:0] fetch(int h, int v);
    int p, fl, rx;
    p  = h / 4;
    fl = v;
    rx = 2 * (p + 1);
    if (p == HT / 4 - 1) begin
      rx = 0;
      fl = (v == VT - 1) ? 0 : v + 1;
    end
    return {9'(rx), 8'(fl < VV ? fl / 2 : 0)};
  endfunction

  task automatic cyc();
    exp_t e;
    bit st;
    st = 1'b0;
    if (reset) begin
      m_al = 0; m_h = 0; m_v = 0; fresh = 1;
      cur = '0;
      cur.hs = 1'b1;
      cur.vs = 1'b1;
      last_hfall = -1;
      last_fs = -1;
    end else begin
      st = m_al && (clockPhase == 3'd3 || clockPhase == 3'd7);
      if (clockPhase == 3'd0) m_al = 1;
      cur.fs = 1'b0;
      if (st) begin
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else m_h++;
        if (m_h >= 4) fresh = 0;
        cur.vis = (m_h < HV) && (m_v < VV);
        cur.hs  = !(m_h >= HSS && m_h < HSE);
        cur.vs  = !(m_v >= VSS && m_v < VSE);
        cur.rgb = (!cur.vis || fresh) ? 8'd0 : mem(m_h / 2, m_v / 2);
        cur.fs  = (m_h == 0) && (m_v == VV);
      end
      {cur.rx, cur.ry} = fetch(m_h, m_v);
    end
    sb.push_back(cur);
    @(posedge clock);
    #1;
    clk_n++;
    e = sb.pop_front();
    check("out", {red, green, blue, hSync, vSync, visible, frameStart},
          {e.rgb, e.hs, e.vs, e.vis, e.fs});
    check("fetch", {readXCoord, readYCoord}, {e.rx, e.ry});
    if (!reset) begin
      if (st && m_v == 0 && m_h < 4 && !fresh)
        check("px_rg", {red, green},
              m_h < 2 ? {3'd7, 3'd0} : {3'd0, 3'd7});
      if (m_v == VT - 1 && m_h >= HT - 4)
        check("wrap_fetch", {readXCoord, readYCoord}, 17'd0);
      if ((m_v == 6 || m_v == 7) && m_h < HT - 4)
        check("dbl_y", readYCoord, 3);
      if (m_v == VV && m_h < HT - 4) begin
        check("blank_y", readYCoord, 0);
        check("blank_rgb", {red, green, blue}, 0);
      end
    end
    if (hs_p && !hSync) begin
      if (last_hfall >= 0) check("line_len", clk_n - last_hfall, 4 * HT);
      last_hfall = clk_n;
      hlow_start = clk_n;
    end
    if (!hs_p && hSync) check("hsync_w", clk_n - hlow_start, 4 * (HSE - HSS));
    if (vs_p && !vSync) vlow_start = clk_n;
    if (!vs_p && vSync)
      check("vsync_w", clk_n - vlow_start, 4 * HT * (VSE - VSS));
    if (frameStart) begin
      if (last_fs >= 0) check("frame_len", clk_n - last_fs, 4 * HT * VT);
      last_fs = clk_n;
      fs_cnt++;
    end
    hs_p = hSync;
    vs_p = vSync;
    clockPhase = clockPhase + 3'd1;
  endtask

  initial begin
    int k, b;
    reset = 1'b1;
    clockPhase = 3'd1;
    repeat (4) cyc();
    reset = 1'b0;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!visible && k < 20);
    check("align_lat", k, 7);

    b = 0;
    while (!(m_v == 1 && m_h == 300) && b < 10000) begin
      cyc();
      b++;
    end
    check("reach_mid", {m_v[15:0], m_h[15:0]}, {16'd1, 16'd300});

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_out",
          {red, green, blue, hSync, vSync, visible, frameStart,
           readXCoord, readYCoord},
          {8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0});

    fs_cnt = 0;
    b = 0;
    while (fs_cnt < 2 && b < 70000) begin
      cyc();
      b++;
    end
    check("frames", fs_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
